// File: rtl/bkt_lvl_finder.sv
// Initiator of the per-level find/backtrack handshake for the level state list.
// It broadcasts the search head, collects the one-hot findindex and bin, pulses apply, and reports the result.
module bkt_lvl_finder #(
  parameter int NUM_LVLS     = 32,
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_IDX    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [WIDTH_LVL-1:0]    max_lvl_i,
  input  logic                    flush_i,
  output logic                    ready_o,
  output logic [1:0]              findflag_head_o,
  output logic [WIDTH_LVL-1:0]    max_lvl_o,
  input  logic [NUM_LVLS-1:0]     findindex_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_i,
  output logic                    apply_bkt_o,
  output logic                    done_o,
  input  logic                    ack_i,
  output logic                    found_o,
  output logic [WIDTH_IDX-1:0]    bkt_lvl_o,
  output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
  output logic                    err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIND,
    S_BIN,
    S_APPLY,
    S_DONE
  } state_t;

  localparam logic [1:0] HEAD_OFF = 2'd2;
  localparam logic [1:0] HEAD_ON  = 2'd0;

  state_t state;

  // Index of the highest set bit; the top-most cell wins if several respond.
  function automatic logic [WIDTH_IDX-1:0] hi_idx(input logic [NUM_LVLS-1:0] v);
    logic [WIDTH_IDX-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LVLS; i++) begin
      if (v[i]) r = WIDTH_IDX'(i);
    end
    return r;
  endfunction

  function automatic logic multi_hot(input logic [NUM_LVLS-1:0] v);
    return (v & (v - NUM_LVLS'(1))) != '0;
  endfunction

  assign ready_o = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      findflag_head_o <= HEAD_OFF;
      max_lvl_o       <= '0;
      apply_bkt_o     <= 1'b0;
      done_o          <= 1'b0;
      found_o         <= 1'b0;
      bkt_lvl_o       <= '0;
      bkt_bin_o       <= '0;
      err_o           <= 1'b0;
    end else if (flush_i && state != S_APPLY) begin
      // Once the apply pulse is out the cells have already changed, so APPLY always completes.
      state           <= S_IDLE;
      findflag_head_o <= HEAD_OFF;
      apply_bkt_o     <= 1'b0;
      done_o          <= 1'b0;
      found_o         <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state           <= S_FIND;
            max_lvl_o       <= max_lvl_i;
            found_o         <= 1'b0;
            err_o           <= 1'b0;
            findflag_head_o <= HEAD_ON;
          end
        end
        S_FIND: begin
          if (findindex_i == '0) begin
            found_o         <= 1'b0;
            bkt_lvl_o       <= '0;
            bkt_bin_o       <= '0;
            findflag_head_o <= HEAD_OFF;
            done_o          <= 1'b1;
            state           <= S_DONE;
          end else begin
            found_o   <= 1'b1;
            bkt_lvl_o <= hi_idx(findindex_i);
            err_o     <= multi_hot(findindex_i);
            state     <= S_BIN;
          end
        end
        S_BIN: begin
          bkt_bin_o   <= bkt_bin_i;
          apply_bkt_o <= 1'b1;
          state       <= S_APPLY;
        end
        S_APPLY: begin
          apply_bkt_o     <= 1'b0;
          findflag_head_o <= HEAD_OFF;
          done_o          <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (ack_i) begin
            done_o <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          state           <= S_IDLE;
          findflag_head_o <= HEAD_OFF;
          apply_bkt_o     <= 1'b0;
          done_o          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bkt_lvl_finder.sv
// Bench for bkt_lvl_finder: vector table, randomized transactions against an arithmetic model, and corner sequences.
module tb_bkt_lvl_finder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] max_lvl_i;
  logic        flush_i;
  logic        ready_o;
  logic [1:0]  findflag_head_o;
  logic [15:0] max_lvl_o;
  logic [31:0] findindex_i;
  logic [9:0]  bkt_bin_i;
  logic        apply_bkt_o;
  logic        done_o;
  logic        ack_i;
  logic        found_o;
  logic [4:0]  bkt_lvl_o;
  logic [9:0]  bkt_bin_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  bkt_lvl_finder dut (
    .clk(clk), .rst(rst), .start_i(start_i), .max_lvl_i(max_lvl_i), .flush_i(flush_i),
    .ready_o(ready_o), .findflag_head_o(findflag_head_o), .max_lvl_o(max_lvl_o),
    .findindex_i(findindex_i), .bkt_bin_i(bkt_bin_i), .apply_bkt_o(apply_bkt_o),
    .done_o(done_o), .ack_i(ack_i), .found_o(found_o), .bkt_lvl_o(bkt_lvl_o),
    .bkt_bin_o(bkt_bin_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] fi;
    logic [9:0]  bin;
    logic [15:0] ml;
    logic        found;
    logic [4:0]  lvl;
    logic [9:0]  ebin;
    logic        err;
    int          lat;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one transaction; findindex and bin are only valid in their own cycles, garbage elsewhere.
  task automatic txn(input logic [31:0] fi, input logic [9:0] bin, input logic [15:0] ml,
                     input logic ef, input logic [4:0] el, input logic [9:0] eb,
                     input logic ee, input int elat, input int hold);
    int apc, apcyc, lat;
    logic ff_ok;
    chk("ready_idle", 32'(ready_o), 1);
    start_i = 1'b1; max_lvl_i = ml;
    findindex_i = $urandom; bkt_bin_i = 10'($urandom);
    step();
    start_i = 1'b0; max_lvl_i = 16'($urandom);
    chk("max_lvl", 32'(max_lvl_o), 32'(ml));
    apc = 0; apcyc = 0; lat = 0; ff_ok = 1'b1;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      if (apply_bkt_o) begin
        apc++; apcyc = n;
        if (findflag_head_o == 2'd2) ff_ok = 1'b0;
      end
      if (done_o) begin
        lat = n;
        if (findflag_head_o != 2'd2) ff_ok = 1'b0;
      end else begin
        if (findflag_head_o != 2'd0) ff_ok = 1'b0;
        findindex_i = (n == 1) ? fi : $urandom;
        bkt_bin_i   = (n == 2) ? bin : 10'($urandom);
        step();
      end
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("apply_count", 32'(apc), ef ? 32'd1 : 32'd0);
    if (ef) chk("apply_cycle", 32'(apcyc), 3);
    chk("findflag_seq", 32'(ff_ok), 1);
    chk("found", 32'(found_o), 32'(ef));
    chk("bkt_lvl", 32'(bkt_lvl_o), 32'(el));
    chk("bkt_bin", 32'(bkt_bin_o), 32'(eb));
    chk("err", 32'(err_o), 32'(ee));
    for (int k = 0; k < hold; k++) begin
      ack_i = 1'b0;
      start_i = (k == 4);
      max_lvl_i = ~ml;
      step();
      start_i = 1'b0;
      chk("done_hold", 32'(done_o), 1);
      chk("ready_hold", 32'(ready_o), 0);
    end
    if (hold > 0) begin
      chk("max_lvl_hold", 32'(max_lvl_o), 32'(ml));
      chk("found_hold", 32'(found_o), 32'(ef));
    end
    ack_i = 1'b1;
    step();
    ack_i = 1'b0;
    chk("done_after_ack", 32'(done_o), 0);
    chk("ready_after_ack", 32'(ready_o), 1);
    chk("found_after_ack", 32'(found_o), 32'(ef));
  endtask

  // Model: highest set bit from log2 of the vector value, error from population count.
  task automatic model_txn(input logic [31:0] fi, input logic [9:0] bin, input logic [15:0] ml);
    int top;
    logic f;
    top = $clog2(64'(fi) + 64'd1) - 1;
    f   = (top >= 0);
    txn(fi, bin, ml, f, f ? 5'(top) : 5'd0, f ? bin : 10'd0,
        $countones(fi) > 1, f ? 4 : 2, 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'h0000_0010, 10'h2A,  16'd7,    1'b1, 5'd4,  10'h2A,  1'b0, 4};
    vecs[1] = '{32'h0000_0000, 10'h155, 16'd3,    1'b0, 5'd0,  10'h000, 1'b0, 2};
    vecs[2] = '{32'h0000_0104, 10'h3C1, 16'd100,  1'b1, 5'd8,  10'h3C1, 1'b1, 4};
    vecs[3] = '{32'h8000_0001, 10'h3FF, 16'hFFFF, 1'b1, 5'd31, 10'h3FF, 1'b1, 4};
    vecs[4] = '{32'h0000_0001, 10'h001, 16'd0,    1'b1, 5'd0,  10'h001, 1'b0, 4};

    rst = 1'b0; start_i = 1'b0; max_lvl_i = '0; flush_i = 1'b0;
    findindex_i = '0; bkt_bin_i = '0; ack_i = 1'b0;
    #12;
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_findflag", 32'(findflag_head_o), 2);
    chk("rst_apply", 32'(apply_bkt_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_found", 32'(found_o), 0);
    chk("rst_max_lvl", 32'(max_lvl_o), 0);
    chk("rst_bkt_lvl", 32'(bkt_lvl_o), 0);
    chk("rst_bkt_bin", 32'(bkt_bin_o), 0);
    chk("rst_err", 32'(err_o), 0);
    @(negedge clk); rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      txn(vecs[i].fi, vecs[i].bin, vecs[i].ml, vecs[i].found, vecs[i].lvl,
          vecs[i].ebin, vecs[i].err, vecs[i].lat, 0);

    // Handshake: long ack wait with a stray start
    txn(32'h0000_0040, 10'h11, 16'd9, 1'b1, 5'd6, 10'h11, 1'b0, 4, 10);

    // Flush in BIN
    start_i = 1'b1; max_lvl_i = 16'd5; step(); start_i = 1'b0;
    findindex_i = 32'h0000_0200; step();
    bkt_bin_i = 10'h77; flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("flush_bin_ready", 32'(ready_o), 1);
    chk("flush_bin_findflag", 32'(findflag_head_o), 2);
    chk("flush_bin_apply", 32'(apply_bkt_o), 0);
    chk("flush_bin_found", 32'(found_o), 0);
    step();
    chk("flush_bin_apply2", 32'(apply_bkt_o), 0);
    chk("flush_bin_done", 32'(done_o), 0);

    // Flush in APPLY is ignored
    start_i = 1'b1; max_lvl_i = 16'd6; step(); start_i = 1'b0;
    findindex_i = 32'h0000_0800; step();
    bkt_bin_i = 10'h0F0; step();
    chk("apply_seen", 32'(apply_bkt_o), 1);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("flush_apply_done", 32'(done_o), 1);
    chk("flush_apply_pulse_end", 32'(apply_bkt_o), 0);
    chk("flush_apply_lvl", 32'(bkt_lvl_o), 11);
    chk("flush_apply_bin", 32'(bkt_bin_o), 32'h0F0);
    ack_i = 1'b1; step(); ack_i = 1'b0;

    // Flush together with start in IDLE
    start_i = 1'b1; flush_i = 1'b1; step(); start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_ready", 32'(ready_o), 1);
    chk("flush_start_findflag", 32'(findflag_head_o), 2);
    step();
    chk("flush_start_ready2", 32'(ready_o), 1);

    // Flush with ack in DONE clears results
    start_i = 1'b1; step(); start_i = 1'b0;
    findindex_i = 32'h0000_0006; step(); step(); step(); step();
    chk("pre_flush_done", 32'(done_o), 1);
    chk("pre_flush_err", 32'(err_o), 1);
    flush_i = 1'b1; ack_i = 1'b1; step(); flush_i = 1'b0; ack_i = 1'b0;
    chk("flush_ack_done", 32'(done_o), 0);
    chk("flush_ack_found", 32'(found_o), 0);
    chk("flush_ack_err", 32'(err_o), 0);
    chk("flush_ack_ready", 32'(ready_o), 1);

    // Async reset in APPLY
    start_i = 1'b1; step(); start_i = 1'b0;
    findindex_i = 32'h0000_0020; step(); step();
    chk("arst_apply_seen", 32'(apply_bkt_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_apply", 32'(apply_bkt_o), 0);
    chk("arst_findflag", 32'(findflag_head_o), 2);
    #1 rst = 1'b1;
    step();
    chk("arst_ready", 32'(ready_o), 1);
    chk("arst_done", 32'(done_o), 0);

    // Randomized transactions against the model
    for (int r = 0; r < 40; r++) begin
      logic [31:0] fi;
      case ($urandom_range(0, 2))
        0:       fi = 32'h0;
        1:       fi = 32'h1 << $urandom_range(0, 31);
        default: fi = $urandom;
      endcase
      model_txn(fi, 10'($urandom), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bkt_lvl_finder.md
Name: bkt_lvl_finder

Overview:
- Initiator side of the per-level find/backtrack protocol in the Sat Engine level state list.
- On request it does three things in order:
  - drives the search chain head and the max level to all level cells;
  - collects the one-hot findindex vector and the backtrack bin;
  - issues the one-cycle apply_bkt pulse that flips or clears has_bkt in the cells.
- Returns the backtrack level and bin to the engine controller with a done/ack handshake.

Parameters:
NUM_LVLS, 32, number of level cells in the chain (level i = cell i, i = 0..NUM_LVLS-1)
WIDTH_LVL, 16, level width
WIDTH_BIN_ID, 10, bin id width
WIDTH_IDX, 5, width of bkt_lvl_o; must satisfy 2^WIDTH_IDX >= NUM_LVLS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start_i  in  1  request a backtrack-level search; accepted only when ready_o=1
max_lvl_i  in  WIDTH_LVL  current max level, sampled with start_i
flush_i  in  1  synchronous abort, returns to IDLE
ready_o  out  1  high in IDLE
findflag_head_o  out  2  chain head findflag: 2 = chain disabled, 0 = search active
max_lvl_o  out  WIDTH_LVL  latched max level broadcast to all cells
findindex_i  in  NUM_LVLS  per-cell findindex, expected one-hot or zero
bkt_bin_i  in  WIDTH_BIN_ID  OR of all cells' registered bkt_bin
apply_bkt_o  out  1  one-cycle apply pulse to all cells
done_o  out  1  result valid, held until ack_i
ack_i  in  1  result consumed
found_o  out  1  a backtrack level exists
bkt_lvl_o  out  WIDTH_IDX  index of the found level
bkt_bin_o  out  WIDTH_BIN_ID  decision bin of the found level
err_o  out  1  findindex_i had more than one bit set

Behaviour:
- Reset (async, rst=0): state IDLE. All registered outputs are 0 except findflag_head_o=2. max_lvl_o=0.
- FSM states: IDLE, FIND, BIN, APPLY, DONE.
- IDLE:
  - ready_o=1, findflag_head_o=2.
  - On start_i: latch max_lvl_i into max_lvl_o, clear err/found, go to FIND.
- FIND (1 cycle):
  - findflag_head_o=0.
  - Sample findindex_i at the end of the cycle (the cells register bkt_bin this cycle).
  - Zero vector: found=0, bkt_lvl=0, bkt_bin=0, go to DONE. No apply pulse.
  - One or more bits set: found=1, bkt_lvl = index of the highest set bit, go to BIN.
  - More than one bit set: additionally err_o=1.
- BIN (1 cycle):
  - findflag_head_o=0.
  - Capture bkt_bin_i into bkt_bin_o, go to APPLY.
- APPLY (1 cycle):
  - findflag_head_o=0, apply_bkt_o=1.
  - max_lvl_o is unchanged from FIND, so the cells see the same findflag.
  - Go to DONE.
- DONE:
  - findflag_head_o=2, done_o=1.
  - found_o, bkt_lvl_o, bkt_bin_o and err_o are stable.
  - On ack_i: go to IDLE. done_o drops the next cycle.
  - Result outputs hold their values until the next start.
- Latency from start_i accepted to done_o:
  - found: 4 cycles (FIND, BIN, APPLY, DONE);
  - not found: 2 cycles.
- start_i outside IDLE is ignored. ack_i outside DONE is ignored.
- flush_i in any state:
  - next state IDLE; apply_bkt_o=0 that cycle; findflag_head_o=2 next cycle.
  - Results are cleared: done=0, found=0, err=0.
  - flush_i is ignored in APPLY: the pulse has already been issued, so the FSM completes to DONE.
  - flush_i in the same cycle as start_i in IDLE: flush wins, start is dropped.
  - flush_i in the same cycle as ack_i in DONE: go to IDLE with results cleared.
- apply_bkt_o is never high for more than one consecutive cycle. It is never high when findflag_head_o=2.
- Reset asserted mid-operation (including APPLY): apply_bkt_o deasserts immediately (async).
- No arithmetic on the level value; max_lvl_o is a straight register copy of width WIDTH_LVL.

Test Plan:
1. Found, single bit:
   - Stimulus: start_i with max_lvl_i=7; findindex_i=32'h0000_0010 in FIND; bkt_bin_i=10'h2A in BIN.
   - Response: apply_bkt_o high exactly 1 cycle (third cycle after start); done_o 4 cycles after start; found_o=1, bkt_lvl_o=4, bkt_bin_o=10'h2A, err_o=0.
2. Not found:
   - Stimulus: findindex_i=0 in FIND.
   - Response: done_o 2 cycles after start; found_o=0, bkt_lvl_o=0, bkt_bin_o=0; apply_bkt_o never asserted.
3. Multi-hot:
   - Stimulus: findindex_i=32'h0000_0104.
   - Response: bkt_lvl_o=8, err_o=1, apply pulse still issued, done_o asserted.
4. Handshake:
   - Stimulus: hold ack_i=0 for 10 cycles in DONE, with a start_i pulse meanwhile; then ack_i=1.
   - Response: done_o stays 1 and the start is ignored; ready_o=1 the cycle after ack.
5. Flush:
   - flush_i in BIN: IDLE next cycle, no apply pulse, findflag_head_o=2.
   - flush_i in APPLY: pulse still issued and the FSM reaches DONE.
   - flush_i together with start_i in IDLE: stays in IDLE.
6. Async reset mid-APPLY:
   - Stimulus: rst low in APPLY.
   - Response: apply_bkt_o=0 and findflag_head_o=2 before the next clock edge; after release, ready_o=1.
